// File: rtl/cdb_arbiter_if.sv
// Bus bundle between the functional units and the CDB transmitter: FU result handshakes in,
// SS broadcast slots out.
interface cdb_arbiter_if #(
    parameter int unsigned SS       = 2,
    parameter int unsigned FU_COUNT = 4,
    parameter int unsigned PREG_W   = 6,
    parameter int unsigned ROB_ID_W = 8
);
    localparam int unsigned IDX_W = (FU_COUNT > 1) ? $clog2(FU_COUNT) : 1;

    logic [FU_COUNT-1:0]               fu_valid;
    logic [FU_COUNT-1:0]               fu_ready;
    logic [FU_COUNT-1:0][PREG_W-1:0]   fu_rd_p;
    logic [FU_COUNT-1:0][ROB_ID_W-1:0] fu_rob_id;
    logic [FU_COUNT-1:0][31:0]         fu_value;

    logic [SS-1:0]                     cdb_valid;
    logic [SS-1:0][PREG_W-1:0]         cdb_rd_p;
    logic [SS-1:0][ROB_ID_W-1:0]       cdb_rob_id;
    logic [SS-1:0][31:0]               cdb_value;
    logic [SS-1:0][IDX_W-1:0]          cdb_fu_idx;

    // Arbiter side.
    modport master (
        input  fu_valid, fu_rd_p, fu_rob_id, fu_value,
        output fu_ready,
        output cdb_valid, cdb_rd_p, cdb_rob_id, cdb_value, cdb_fu_idx
    );

    // FU producers and CDB consumers.
    modport slave (
        output fu_valid, fu_rd_p, fu_rob_id, fu_value,
        input  fu_ready,
        input  cdb_valid, cdb_rd_p, cdb_rob_id, cdb_value, cdb_fu_idx
    );
endinterface

// File: rtl/cdb_arbiter.sv
// CDB transmitter: per-FU result FIFOs feeding a round-robin arbiter that broadcasts up to
// SS results per cycle on registered CDB slots.
module cdb_arbiter #(
    parameter int unsigned SS         = 2,
    parameter int unsigned FU_COUNT   = 4,
    parameter int unsigned FIFO_DEPTH = 2,
    parameter int unsigned PREG_W     = 6,
    parameter int unsigned ROB_ID_W   = 8
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          flush,
    cdb_arbiter_if.master bus
);
    localparam int unsigned IDX_W  = (FU_COUNT > 1) ? $clog2(FU_COUNT) : 1;
    localparam int unsigned PTR_W  = $clog2(FIFO_DEPTH);
    localparam int unsigned CNT_W  = $clog2(FIFO_DEPTH + 1);
    localparam int unsigned SLOT_W = (SS > 1) ? $clog2(SS) : 1;
    localparam int unsigned GNT_W  = $clog2(SS + 1);

    typedef struct packed {
        logic [PREG_W-1:0]   rd_p;
        logic [ROB_ID_W-1:0] rob_id;
        logic [31:0]         value;
    } entry_t;

    entry_t           mem_q    [FU_COUNT][FIFO_DEPTH];
    logic [PTR_W-1:0] rd_ptr_q [FU_COUNT];
    logic [PTR_W-1:0] wr_ptr_q [FU_COUNT];
    logic [CNT_W-1:0] count_q  [FU_COUNT];
    entry_t           head     [FU_COUNT];

    logic [IDX_W-1:0]    rr_ptr_q, rr_ptr_d;
    logic [FU_COUNT-1:0] fu_ready;
    logic [FU_COUNT-1:0] push, pop, not_empty;

    logic [SS-1:0]    slot_vld;
    logic [IDX_W-1:0] slot_fu [SS];
    logic [GNT_W-1:0] n_grant;
    logic [IDX_W-1:0] last_fu;
    logic [IDX_W-1:0] idx;

    logic [SS-1:0]               cdb_valid_q;
    logic [SS-1:0][PREG_W-1:0]   cdb_rd_p_q;
    logic [SS-1:0][ROB_ID_W-1:0] cdb_rob_id_q;
    logic [SS-1:0][31:0]         cdb_value_q;
    logic [SS-1:0][IDX_W-1:0]    cdb_fu_idx_q;

    // Ready depends on the registered count only, so a full FIFO never passes through.
    always_comb begin
        fu_ready  = '0;
        push      = '0;
        not_empty = '0;
        for (int i = 0; i < FU_COUNT; i++) begin
            fu_ready[i]  = !rst && (count_q[i] < CNT_W'(FIFO_DEPTH));
            push[i]      = bus.fu_valid[i] && fu_ready[i] && !flush;
            not_empty[i] = (count_q[i] != '0);
            head[i]      = mem_q[i][rd_ptr_q[i]];
        end
    end

    assign bus.fu_ready = fu_ready;

    always_comb begin
        pop      = '0;
        slot_vld = '0;
        n_grant  = '0;
        last_fu  = rr_ptr_q;
        idx      = '0;
        for (int s = 0; s < SS; s++) begin
            slot_fu[s] = '0;
        end
        for (int k = 0; k < FU_COUNT; k++) begin
            idx = IDX_W'((int'(rr_ptr_q) + k) % int'(FU_COUNT));
            if (not_empty[idx] && (n_grant < GNT_W'(SS))) begin
                pop[idx]                         = 1'b1;
                slot_vld[n_grant[SLOT_W-1:0]]    = 1'b1;
                slot_fu[n_grant[SLOT_W-1:0]]     = idx;
                last_fu                          = idx;
                n_grant                          = n_grant + GNT_W'(1);
            end
        end
        // Flush wins over any grant: nothing pops and nothing is broadcast.
        if (flush) begin
            pop      = '0;
            slot_vld = '0;
        end

        rr_ptr_d = rr_ptr_q;
        if (flush) begin
            rr_ptr_d = '0;
        end else if (n_grant != '0) begin
            rr_ptr_d = (last_fu == IDX_W'(FU_COUNT - 1)) ? '0 : last_fu + IDX_W'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rr_ptr_q <= '0;
            for (int i = 0; i < FU_COUNT; i++) begin
                rd_ptr_q[i] <= '0;
                wr_ptr_q[i] <= '0;
                count_q[i]  <= '0;
            end
        end else begin
            rr_ptr_q <= rr_ptr_d;
            for (int i = 0; i < FU_COUNT; i++) begin
                if (flush) begin
                    rd_ptr_q[i] <= '0;
                    wr_ptr_q[i] <= '0;
                    count_q[i]  <= '0;
                end else begin
                    if (push[i]) begin
                        wr_ptr_q[i] <= wr_ptr_q[i] + PTR_W'(1);
                    end
                    if (pop[i]) begin
                        rd_ptr_q[i] <= rd_ptr_q[i] + PTR_W'(1);
                    end
                    count_q[i] <= count_q[i] + CNT_W'(push[i]) - CNT_W'(pop[i]);
                end
            end
        end
    end

    // Payload storage needs no reset; occupancy is tracked by the counters.
    always_ff @(posedge clk) begin
        for (int i = 0; i < FU_COUNT; i++) begin
            if (push[i]) begin
                mem_q[i][wr_ptr_q[i]] <= '{rd_p:   bus.fu_rd_p[i],
                                           rob_id: bus.fu_rob_id[i],
                                           value:  bus.fu_value[i]};
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cdb_valid_q  <= '0;
            cdb_rd_p_q   <= '0;
            cdb_rob_id_q <= '0;
            cdb_value_q  <= '0;
            cdb_fu_idx_q <= '0;
        end else begin
            cdb_valid_q <= slot_vld;
            for (int s = 0; s < SS; s++) begin
                if (slot_vld[s]) begin
                    cdb_rd_p_q[s]   <= head[slot_fu[s]].rd_p;
                    cdb_rob_id_q[s] <= head[slot_fu[s]].rob_id;
                    cdb_value_q[s]  <= head[slot_fu[s]].value;
                    cdb_fu_idx_q[s] <= slot_fu[s];
                end
            end
        end
    end

    assign bus.cdb_valid  = cdb_valid_q;
    assign bus.cdb_rd_p   = cdb_rd_p_q;
    assign bus.cdb_rob_id = cdb_rob_id_q;
    assign bus.cdb_value  = cdb_value_q;
    assign bus.cdb_fu_idx = cdb_fu_idx_q;

endmodule

// File: doc/cdb_arbiter.md
Name: cdb_arbiter

Overview:
- Transmitter side of the common data bus (CDB). Collects completed results from all functional units, buffers them per FU, and broadcasts up to SS results per cycle.
- Consumers of the broadcast: the physical register file (value write, dependency clear), reservation stations (wakeup) and the ROB (completion).
- Sits between FU outputs and all CDB consumers. It is the only driver of CDB valid/data.

Parameters:
- SS, 2, number of CDB broadcast slots per cycle.
- FU_COUNT, 4, number of functional-unit result sources.
- FIFO_DEPTH, 2, result buffer entries per FU (power of two, >=2).
- PREG_W, 6, physical register index width (64 entries).
- ROB_ID_W, 8, ROB entry ID width.

Ports:
- clk  in  1  clock; all state on rising edge.
- rst  in  1  asynchronous, active-high reset.
- flush  in  1  synchronous pipeline flush (mispredict); discards all buffered results.
- fu_valid[FU_COUNT]  in  1  FU presents a completed result.
- fu_ready[FU_COUNT]  out  1  buffer for that FU can accept this cycle.
- fu_rd_p[FU_COUNT]  in  PREG_W  destination physical register.
- fu_rob_id[FU_COUNT]  in  ROB_ID_W  ROB entry of the producing instruction.
- fu_value[FU_COUNT]  in  32  result data.
- cdb_valid[SS]  out  1  slot carries a broadcast this cycle.
- cdb_rd_p[SS]  out  PREG_W  broadcast destination physical register.
- cdb_rob_id[SS]  out  ROB_ID_W  broadcast ROB ID.
- cdb_value[SS]  out  32  broadcast value.
- cdb_fu_idx[SS]  out  $clog2(FU_COUNT)  source FU of the slot (debug/perf).

Behaviour:
- Reset (async, rst=1):
  - All FIFO counts, read pointers and write pointers clear to 0.
  - Round-robin pointer rr_ptr clears to 0.
  - All cdb_* outputs clear to 0.
  - fu_ready goes to 1 once rst deasserts; fu_ready is 0 while rst is asserted.
- Per-FU FIFO:
  - Push when fu_valid && fu_ready.
  - fu_ready = (count < FIFO_DEPTH), computed combinationally from the registered count only. A full FIFO does not report ready even if a pop occurs in the same cycle (no pass-through).
  - Push and pop in the same cycle leaves count unchanged.
  - Pointers wrap modulo FIFO_DEPTH.
- Arbitration (combinational, from FIFO heads):
  - Scan FU indices starting at rr_ptr, wrapping modulo FU_COUNT.
  - Grant the first SS non-empty FIFOs found. Slot 0 gets the first grant, slot 1 the second, and so on.
  - A FU receives at most one grant per cycle.
  - Each granted FIFO pops its head in that cycle.
- rr_ptr update:
  - If at least one grant: next rr_ptr = (index of last granted FU + 1) mod FU_COUNT.
  - If no grants: rr_ptr is unchanged.
- Outputs and latency:
  - cdb_* are registered. Granted head data appears on cdb_* on the following edge.
  - Ungranted slots have cdb_valid=0. Data fields of invalid slots hold their last value.
  - Minimum latency from fu_valid accepted at edge N to cdb_valid at edge N+1 is one cycle, because an empty FIFO's head becomes available after the push edge and is broadcast the next cycle.
  - Steady-state throughput is min(SS, non-empty FIFOs) results per cycle.
- rd_p = 0 results are broadcast normally. Consumers ignore register writes to p0, but the ROB still needs the completion.
- Flush:
  - On the edge where flush=1, all FIFOs empty, rr_ptr resets to 0, and all cdb_valid go to 0.
  - Pushes in the flush cycle are dropped.
  - fu_ready in the cycle after flush is 1 for all FUs.
- Simultaneous events:
  - Flush overrides push and pop.
  - Reset overrides everything, including mid-broadcast. Outputs drop asynchronously.
- Ordering: results from the same FU broadcast in acceptance order. No ordering is guaranteed across FUs.

Test Plan:
- Single result: reset; FU1 valid with rd_p=5, rob=3, value=0xDEADBEEF for one cycle -> next cycle cdb_valid[0]=1 with those fields and cdb_fu_idx[0]=1; cdb_valid[1]=0; following cycle all cdb_valid=0.
- Dual broadcast: FU0 and FU2 valid in the same cycle (rd 7/9) -> next cycle slot0 = FU0 (rd 7), slot1 = FU2 (rd 9); rr_ptr becomes 3.
- Contention/round-robin: FU0, FU1, FU2 each push one result in the same cycle ->
  - Cycle 1: slots = FU0, FU1.
  - Cycle 2: slot0 = FU2, slot1 invalid.
  - Repeat the pattern with rr_ptr=3: FU0 and FU1 are broadcast first.
- Backpressure: hold FU3 valid for 4 consecutive cycles while FUs 0-2 each hold valid to keep them non-empty ->
  - fu_ready[3] drops only when count=2.
  - No result is lost or duplicated; FU3 values appear in push order.
- Flush: fill FU0 with 2 entries, assert flush in the cycle FU1 pushes -> next cycle all cdb_valid=0, fu_ready all 1, and no stale value is broadcast afterward.
- Async reset: assert rst mid-cycle while cdb_valid[0]=1 -> cdb_valid drops immediately without a clock edge; after deassert, the first accepted result is broadcast with cdb_fu_idx starting the scan at 0.
